// File: rtl/crossing_sequencer.sv
// Level-crossing sequencer: warning lamps, amber/red phases, barrier lower/raise,
// occupancy tracking by approach/depart edge counting, tick-based dwell timers.
// Optional OCCUPIED watchdog with FAULT state, enabled by macro CROSSING_WATCHDOG_EN.
// All parameters must lie in 1..65535; timers and prescaler are 16 bits wide.
module crossing_sequencer #(
    parameter int TICK_DIV = 50000,
    parameter int T_WARN   = 3000,
    parameter int T_AMBER  = 2000,
    parameter int T_RED    = 1000,
    parameter int T_LOWER  = 4000,
    parameter int T_RAISE  = 4000,
    parameter int T_CLEAR  = 1000,
    parameter int T_WATCH  = 60000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       approach,
    input  logic       depart,
    input  logic       maint_clr,
    output logic [3:0] present_state,
    output logic       y,
    output logic [1:0] train_cnt,
    output logic       busy,
    output logic       fault
);

    // Internal state identifiers (distinct from output codes, which repeat)
    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_WARN  = 4'd1;
    localparam logic [3:0] S_AMBER = 4'd2;
    localparam logic [3:0] S_RED   = 4'd3;
    localparam logic [3:0] S_LOWER = 4'd4;
    localparam logic [3:0] S_OCC   = 4'd5;
    localparam logic [3:0] S_RAISE = 4'd6;
    localparam logic [3:0] S_CLEAR = 4'd7;
`ifdef CROSSING_WATCHDOG_EN
    localparam logic [3:0] S_FAULT = 4'd8;
`endif

    logic [3:0]  state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [15:0] presc_q, presc_d;
    logic [1:0]  sens, sens_q, sens_d, sens_rise;
    logic [1:0]  cnt_q, cnt_d;
    logic [3:0]  ps_q, ps_d;
    logic        y_q, y_d;
    logic        fault_q, fault_d;
    logic        tick;
    logic        timer_done;
    logic        app_rise, dep_rise;

    // Sensor vector: bit 0 approach, bit 1 depart
    assign sens = {depart, approach};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_edge
            assign sens_rise[gi] = sens[gi] & ~sens_q[gi];
        end
    endgenerate

    assign app_rise = sens_rise[0];
    assign dep_rise = sens_rise[1];

    // Free-running prescaler producing a one-cycle tick every TICK_DIV clocks
    always_comb begin
        tick    = (presc_q == 16'(TICK_DIV - 1));
        presc_d = tick ? 16'd0 : presc_q + 16'd1;
        sens_d  = sens;
    end

    // Train counter: saturating up on approach, flooring down on depart, hold on coincidence
    always_comb begin
        cnt_d = cnt_q;
        if (app_rise && !dep_rise && cnt_q != 2'd3) begin
            cnt_d = cnt_q + 2'd1;
        end else if (dep_rise && !app_rise && cnt_q != 2'd0) begin
            cnt_d = cnt_q - 2'd1;
        end
    end

`ifdef CROSSING_WATCHDOG_EN
    logic [15:0] watch_q, watch_d;
`else
    // Watchdog absent: maintenance clear and watchdog limit have no effect
    logic unused_cfg;
    assign unused_cfg = maint_clr | (T_WATCH == 0);
`endif

    // Next-state logic: dwell timer counts down on ticks, transition when it expires at 0
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        timer_done = tick && (timer_q == 16'd0);
        if (tick && timer_q != 16'd0) begin
            timer_d = timer_q - 16'd1;
        end
`ifdef CROSSING_WATCHDOG_EN
        watch_d = watch_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cnt_q != 2'd0 || (app_rise && !dep_rise)) begin
                    state_d = S_WARN;
                    timer_d = 16'(T_WARN - 1);
                end
            end
            S_WARN: if (timer_done) begin
                state_d = S_AMBER;
                timer_d = 16'(T_AMBER - 1);
            end
            S_AMBER: if (timer_done) begin
                state_d = S_RED;
                timer_d = 16'(T_RED - 1);
            end
            S_RED: if (timer_done) begin
                state_d = S_LOWER;
                timer_d = 16'(T_LOWER - 1);
            end
            S_LOWER: if (timer_done) begin
                state_d = S_OCC;
                timer_d = 16'd0;
`ifdef CROSSING_WATCHDOG_EN
                watch_d = 16'd0;
`endif
            end
            S_OCC: begin
                // Section empty (possibly already on entry): lift barriers
                if (cnt_q == 2'd0) begin
                    state_d = S_RAISE;
                    timer_d = 16'(T_RAISE - 1);
                end
`ifdef CROSSING_WATCHDOG_EN
                else if (tick) begin
                    if (watch_q == 16'(T_WATCH - 1)) begin
                        state_d = S_FAULT;
                    end else begin
                        watch_d = watch_q + 16'd1;
                    end
                end
`endif
            end
            S_RAISE: if (timer_done) begin
                state_d = S_CLEAR;
                timer_d = 16'(T_CLEAR - 1);
            end
            S_CLEAR: if (timer_done) begin
                state_d = S_IDLE;
                timer_d = 16'd0;
            end
`ifdef CROSSING_WATCHDOG_EN
            S_FAULT: begin
                // Barriers stay down until maintenance confirms an empty section
                if (maint_clr && cnt_q == 2'd0) begin
                    state_d = S_RAISE;
                    timer_d = 16'(T_RAISE - 1);
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                timer_d = 16'd0;
            end
        endcase
    end

    // Output code decode from the next state so the registered code tracks transitions
    always_comb begin
        ps_d = 4'b0000;
        y_d  = 1'b0;
        case (state_d)
            S_WARN:  ps_d = 4'b0011;
            S_AMBER: ps_d = 4'b0100;
            S_RED:   ps_d = 4'b0101;
            S_LOWER: ps_d = 4'b0110;
            S_OCC:   begin ps_d = 4'b0110; y_d = 1'b1; end
            S_RAISE: begin ps_d = 4'b1010; y_d = 1'b1; end
            S_CLEAR: begin ps_d = 4'b1011; y_d = 1'b1; end
`ifdef CROSSING_WATCHDOG_EN
            S_FAULT: begin ps_d = 4'b0110; y_d = 1'b1; end
`endif
            default: begin ps_d = 4'b0000; y_d = 1'b0; end
        endcase
`ifdef CROSSING_WATCHDOG_EN
        fault_d = (state_d == S_FAULT);
`else
        fault_d = 1'b0;
`endif
    end

    // State, timers, counters and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            timer_q <= 16'd0;
            presc_q <= 16'd0;
            sens_q  <= 2'b00;
            cnt_q   <= 2'd0;
            ps_q    <= 4'b0000;
            y_q     <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            presc_q <= presc_d;
            sens_q  <= sens_d;
            cnt_q   <= cnt_d;
            ps_q    <= ps_d;
            y_q     <= y_d;
            fault_q <= fault_d;
        end
    end

`ifdef CROSSING_WATCHDOG_EN
    // Watchdog tick counter for OCCUPIED
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            watch_q <= 16'd0;
        end else begin
            watch_q <= watch_d;
        end
    end
`endif

    assign present_state = ps_q;
    assign y             = y_q;
    assign train_cnt     = cnt_q;
    assign busy          = (state_q != S_IDLE);
    assign fault         = fault_q;

endmodule
